// File: rtl/sdram_port_scheduler_pkg.sv
// Shared definitions for the SDRAM port scheduler: FSM state encoding and
// default tuning values for burst cap and starvation limit.
package sdram_port_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    localparam int DEF_WB_PORTS     = 3;
    localparam int DEF_MAX_BURST    = 8;
    localparam int DEF_STARVE_LIMIT = 64;

endpackage

// File: rtl/sdram_port_scheduler_rr_pick.sv
// Combinational arbiter: a starved requester (lowest index) beats round-robin,
// otherwise the first requester after ptr_i wins, wrapping to port 0.
module sdram_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic [N-1:0]     starved_i,
    output logic [N-1:0]     win_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             valid_o,
    output logic             starve_win_o
);

    always_comb begin
        int cand;
        cand         = 0;
        win_idx_o    = '0;
        valid_o      = 1'b0;
        starve_win_o = 1'b0;
        win_o        = '0;
        // Scan downwards so the lowest starved index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (starved_i[i] && req_i[i]) begin
                win_idx_o    = IDX_W'(i);
                starve_win_o = 1'b1;
                valid_o      = 1'b1;
            end
        end
        if (!starve_win_o) begin
            for (int off = N; off >= 1; off--) begin
                cand = (int'(ptr_i) + off) % N;
                if (req_i[cand]) begin
                    win_idx_o = IDX_W'(cand);
                    valid_o   = 1'b1;
                end
            end
        end
        if (valid_o) begin
            win_o[win_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Shares one SDRAM controller port among WB_PORTS requesters with round-robin,
// a per-grant burst cap and starvation override; switches only when idle.
module sdram_port_scheduler
    import sdram_port_scheduler_pkg::*;
#(
    parameter int WB_PORTS     = DEF_WB_PORTS,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst_n,
    input  logic [WB_PORTS-1:0]    p_acc_i,
    input  logic [WB_PORTS*32-1:0] p_adr_i,
    input  logic [WB_PORTS*16-1:0] p_dat_i,
    input  logic [WB_PORTS*2-1:0]  p_sel_i,
    input  logic [WB_PORTS-1:0]    p_we_i,
    output logic [WB_PORTS-1:0]    p_ack_o,
    output logic [15:0]            p_dat_o,
    output logic [WB_PORTS-1:0]    grant_o,
    input  logic                   sdram_idle_i,
    output logic                   acc_o,
    output logic [31:0]            adr_o,
    output logic [15:0]            dat_o,
    output logic [1:0]             sel_o,
    output logic                   we_o,
    input  logic                   ack_i,
    input  logic [15:0]            dat_i
);

    localparam int IDX_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);
    localparam int WC_W  = $clog2(STARVE_LIMIT + 1);

    sched_state_e          state_q, state_d;
    logic [WB_PORTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [WC_W-1:0]       wait_cnt_q [WB_PORTS];
    logic [WC_W-1:0]       wait_cnt_d [WB_PORTS];

    logic [WB_PORTS-1:0]   starved;
    logic [IDX_W-1:0]      pick_ptr;
    logic [WB_PORTS-1:0]   pick_win;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic                  pick_starve;

    // While draining, the current owner is placed last in round-robin order.
    assign pick_ptr = (state_q == ST_DRAIN) ? gidx_q : rr_ptr_q;

    sdram_rr_pick #(
        .N     (WB_PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i        (p_acc_i),
        .ptr_i        (pick_ptr),
        .starved_i    (starved),
        .win_o        (pick_win),
        .win_idx_o    (pick_idx),
        .valid_o      (pick_valid),
        .starve_win_o (pick_starve)
    );

    always_comb begin
        for (int k = 0; k < WB_PORTS; k++) begin
            starved[k] = (wait_cnt_q[k] == WC_W'(STARVE_LIMIT));
            if (!p_acc_i[k] || grant_q[k]) begin
                wait_cnt_d[k] = '0;
            end else if (!starved[k]) begin
                wait_cnt_d[k] = wait_cnt_q[k] + 1'b1;
            end else begin
                wait_cnt_d[k] = wait_cnt_q[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sdram_idle_i && pick_valid) begin
                    state_d     = ST_GRANT;
                    grant_d     = pick_win;
                    gidx_d      = pick_idx;
                    burst_cnt_d = '0;
                    if (!pick_starve) rr_ptr_d = pick_idx;
                end
            end
            ST_GRANT: begin
                if (ack_i && burst_cnt_q != BC_W'(MAX_BURST)) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                if ((ack_i && burst_cnt_q == BC_W'(MAX_BURST - 1)) || !p_acc_i[gidx_q]) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sdram_idle_i) begin
                    if (pick_valid) begin
                        state_d     = ST_GRANT;
                        grant_d     = pick_win;
                        gidx_d      = pick_idx;
                        burst_cnt_d = '0;
                        if (!pick_starve) rr_ptr_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= IDX_W'(WB_PORTS - 1);
            burst_cnt_q <= '0;
            for (int k = 0; k < WB_PORTS; k++) wait_cnt_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            for (int k = 0; k < WB_PORTS; k++) wait_cnt_q[k] <= wait_cnt_d[k];
        end
    end

    always_comb begin
        acc_o   = 1'b0;
        adr_o   = '0;
        dat_o   = '0;
        sel_o   = '0;
        we_o    = 1'b0;
        p_ack_o = '0;
        if (state_q != ST_IDLE) begin
            adr_o   = p_adr_i[gidx_q*32 +: 32];
            dat_o   = p_dat_i[gidx_q*16 +: 16];
            sel_o   = p_sel_i[gidx_q*2 +: 2];
            we_o    = p_we_i[gidx_q];
            p_ack_o = grant_q & {WB_PORTS{ack_i}};
            acc_o   = (state_q == ST_GRANT) && p_acc_i[gidx_q];
        end
    end

    assign grant_o = grant_q;
    assign p_dat_o = dat_i;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Self-checking bench for sdram_port_scheduler: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_sdram_port_scheduler;

    localparam int N  = 3;
    localparam int MB = 8;
    localparam int SL = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  acc;
    logic [N*32-1:0] adr;
    logic [N*16-1:0] dat;
    logic [N*2-1:0]  sel;
    logic [N-1:0]  we;
    logic          idle;
    logic          ack;
    logic [15:0]   cdat;

    logic [N-1:0]  p_ack_o;
    logic [15:0]   p_dat_o;
    logic [N-1:0]  grant_o;
    logic          acc_o;
    logic [31:0]   adr_o;
    logic [15:0]   dat_o;
    logic [1:0]    sel_o;
    logic          we_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase 0 = no owner, 1 = owner served, 2 = owner finishing.
    int m_phase;
    int m_owner;
    int m_beats;
    int m_last;
    int m_wait [N];

    always #5 clk = ~clk;

    sdram_port_scheduler #(
        .WB_PORTS     (N),
        .MAX_BURST    (MB),
        .STARVE_LIMIT (SL)
    ) dut (
        .sdram_clk    (clk),
        .sdram_rst_n  (rst_n),
        .p_acc_i      (acc),
        .p_adr_i      (adr),
        .p_dat_i      (dat),
        .p_sel_i      (sel),
        .p_we_i       (we),
        .p_ack_o      (p_ack_o),
        .p_dat_o      (p_dat_o),
        .grant_o      (grant_o),
        .sdram_idle_i (idle),
        .acc_o        (acc_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .sel_o        (sel_o),
        .we_o         (we_o),
        .ack_i        (ack),
        .dat_i        (cdat)
    );

    wire [73:0] dut_vec = {grant_o, acc_o, p_ack_o, adr_o, dat_o, sel_o, we_o, p_dat_o};

    function automatic int m_pick(input logic [N-1:0] req, input int after, output bit starved_win);
        starved_win = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (req[k] && m_wait[k] == SL) begin
                starved_win = 1'b1;
                return k;
            end
        end
        for (int s = 1; s <= N; s++) begin
            if (req[(after + s) % N]) return (after + s) % N;
        end
        return -1;
    endfunction

    function automatic logic m_acc();
        return (m_phase == 1) && acc[m_owner];
    endfunction

    function automatic logic [73:0] m_out();
        logic [N-1:0] g;
        logic [N-1:0] a;
        logic [31:0]  ad;
        logic [15:0]  d;
        logic [1:0]   s;
        logic         w;
        g = '0; a = '0; ad = '0; d = '0; s = '0; w = 1'b0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            ad = adr[m_owner*32 +: 32];
            d  = dat[m_owner*16 +: 16];
            s  = sel[m_owner*2 +: 2];
            w  = we[m_owner];
            if (ack) a = g;
        end
        return {g, m_acc(), a, ad, d, s, w, cdat};
    endfunction

    task automatic model_update();
        int  nw [N];
        int  win;
        bit  sw;
        if (!rst_n) begin
            m_phase = 0; m_owner = -1; m_beats = 0; m_last = N - 1;
            for (int k = 0; k < N; k++) m_wait[k] = 0;
            return;
        end
        for (int k = 0; k < N; k++) begin
            if (!acc[k] || m_owner == k) nw[k] = 0;
            else nw[k] = (m_wait[k] < SL) ? m_wait[k] + 1 : SL;
        end
        win = -1;
        sw  = 1'b0;
        if (m_phase == 0 && acc != '0 && idle) begin
            win = m_pick(acc, m_last, sw);
        end else if (m_phase == 1) begin
            if (ack) m_beats++;
            if ((ack && m_beats == MB) || !acc[m_owner]) m_phase = 2;
        end else if (m_phase == 2 && idle) begin
            win = m_pick(acc, m_owner, sw);
            if (win < 0) begin
                m_phase = 0;
                m_owner = -1;
            end
        end
        if (win >= 0) begin
            m_phase = 1;
            m_owner = win;
            m_beats = 0;
            if (!sw) m_last = win;
        end
        for (int k = 0; k < N; k++) m_wait[k] = nw[k];
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; acc = '1; ack = 1'b1; idle = 1'b1; cdat = 16'hbeef;
        advance();
        advance();
        rst_n = 1'b1; acc = '0;
        @(negedge clk);
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=000", grant_o); end
        checks++; if (acc_o !== 1'b0) begin errors++; $display("FAIL reset_acc got=%b exp=0", acc_o); end
        checks++; if (p_ack_o !== 3'b000) begin errors++; $display("FAIL reset_ack got=%b exp=000", p_ack_o); end
        checks++; if ({adr_o, dat_o, sel_o, we_o} !== 51'd0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {adr_o, dat_o, sel_o, we_o}); end
        checks++; if (p_dat_o !== 16'hbeef) begin errors++; $display("FAIL reset_pdat got=%h exp=beef", p_dat_o); end
        ack = 1'b0;
        advance();
    endtask

    task automatic test_stray_ack();
        acc = '0; ack = 1'b1; idle = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (p_ack_o !== 3'b000 || grant_o !== 3'b000) begin
                errors++; $display("FAIL stray_ack cycle=%0d ack=%b grant=%b exp=000/000", i, p_ack_o, grant_o);
            end
            advance();
        end
        ack = 1'b0;
    endtask

    task automatic test_single_port();
        int acks;
        acks = 0;
        acc = 3'b001; we = 3'b001; idle = 1'b1; ack = 1'b0;
        adr[31:0] = 32'h1000_0040; dat[15:0] = 16'h1234; sel[1:0] = 2'b11;
        @(negedge clk);
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL single_latency got=%b exp=000", grant_o); end
        advance();
        @(negedge clk);
        checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL single_grant got=%b exp=001", grant_o); end
        checks++; if ({acc_o, adr_o, we_o} !== {1'b1, 32'h1000_0040, 1'b1}) begin
            errors++; $display("FAIL single_bus got=%b/%h/%b exp=1/10000040/1", acc_o, adr_o, we_o);
        end
        for (int i = 0; i < 3; i++) begin
            ack = 1'b1;
            dat[15:0] = 16'h1234 + 16'(i);
            @(negedge clk);
            if (p_ack_o === 3'b001 && dat_o === dat[15:0]) acks++;
            advance();
        end
        checks++; if (acks !== 3) begin errors++; $display("FAIL single_acks got=%0d exp=3", acks); end
        ack = 1'b0; acc = 3'b000;
        @(negedge clk);
        checks++; if (acc_o !== 1'b0) begin errors++; $display("FAIL single_drop_acc got=%b exp=0", acc_o); end
        advance();
        @(negedge clk);
        checks++; if ({grant_o, acc_o, adr_o} !== {3'b001, 1'b0, 32'h1000_0040}) begin
            errors++; $display("FAIL single_drain got=%b/%b/%h exp=001/0/10000040", grant_o, acc_o, adr_o);
        end
        advance();
        @(negedge clk);
        checks++; if ({grant_o, adr_o} !== 35'd0) begin errors++; $display("FAIL single_idle got=%b/%h exp=000/0", grant_o, adr_o); end
        advance();
    endtask

    task automatic test_round_robin();
        int seq [$];
        int exp_owner [4];
        int same;
        exp_owner = '{0, 1, 2, 0};
        rst_n = 1'b0; advance(); rst_n = 1'b1;
        acc = 3'b111; idle = 1'b1;
        for (int c = 0; c < 300 && seq.size() < 32; c++) begin
            ack = m_acc();
            @(negedge clk);
            if (m_phase == 2) begin
                checks++;
                if (acc_o !== 1'b0) begin errors++; $display("FAIL rr_drain_acc cycle=%0d got=%b exp=0", c, acc_o); end
            end
            case (p_ack_o)
                3'b001: seq.push_back(0);
                3'b010: seq.push_back(1);
                3'b100: seq.push_back(2);
                default: ;
            endcase
            advance();
        end
        checks++;
        if (seq.size() != 32) begin
            errors++; $display("FAIL rr_ack_total got=%0d exp=32", seq.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                same = 0;
                for (int j = 0; j < 8; j++) if (seq[b*8 + j] == exp_owner[b]) same++;
                checks++;
                if (same != 8) begin errors++; $display("FAIL rr_block%0d acks_to_port%0d got=%0d exp=8", b, exp_owner[b], same); end
            end
        end
        acc = '0; ack = 1'b0;
        repeat (3) advance();
    endtask

    task automatic test_starvation();
        rst_n = 1'b0; advance(); rst_n = 1'b1;
        acc = 3'b001; idle = 1'b1; ack = 1'b0;
        advance();
        acc = 3'b101;
        for (int i = 0; i < MB; i++) begin
            ack = 1'b1;
            advance();
        end
        ack = 1'b0; idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 80) acc = 3'b111;
            @(negedge clk);
            checks++;
            if (grant_o !== 3'b001 || acc_o !== 1'b0) begin
                errors++; $display("FAIL starve_frozen cycle=%0d got=%b/%b exp=001/0", i, grant_o, acc_o);
            end
            advance();
        end
        idle = 1'b1;
        advance();
        @(negedge clk);
        checks++; if (grant_o !== 3'b100) begin errors++; $display("FAIL starve_winner got=%b exp=100", grant_o); end
        acc = '0;
        repeat (3) advance();
    endtask

    task automatic test_drop_last_ack();
        rst_n = 1'b0; advance(); rst_n = 1'b1;
        acc = 3'b001; idle = 1'b1; ack = 1'b0;
        advance();
        for (int i = 0; i < MB - 1; i++) begin
            ack = 1'b1;
            advance();
        end
        ack = 1'b1; acc = 3'b000;
        @(negedge clk);
        checks++; if (p_ack_o !== 3'b001) begin errors++; $display("FAIL drop_ack_fwd got=%b exp=001", p_ack_o); end
        advance();
        ack = 1'b0; acc = 3'b001;
        @(negedge clk);
        checks++; if ({grant_o, acc_o} !== 4'b0010) begin errors++; $display("FAIL drop_drain got=%b/%b exp=001/0", grant_o, acc_o); end
        advance();
        for (int i = 0; i < MB - 1; i++) begin
            ack = 1'b1;
            advance();
        end
        @(negedge clk);
        checks++; if ({grant_o, acc_o} !== 4'b0011) begin errors++; $display("FAIL drop_cnt_reset got=%b/%b exp=001/1", grant_o, acc_o); end
        advance();
        ack = 1'b0;
        @(negedge clk);
        checks++; if ({grant_o, acc_o} !== 4'b0010) begin errors++; $display("FAIL drop_second_drain got=%b/%b exp=001/0", grant_o, acc_o); end
        acc = '0;
        repeat (3) advance();
    endtask

    task automatic test_reset_mid_grant();
        acc = 3'b001; idle = 1'b1; ack = 1'b0;
        advance();
        ack = 1'b1;
        advance();
        advance();
        rst_n = 1'b0;
        advance();
        @(negedge clk);
        checks++; if ({grant_o, acc_o, p_ack_o} !== 7'd0) begin
            errors++; $display("FAIL rst_mid got=%b/%b/%b exp=000/0/000", grant_o, acc_o, p_ack_o);
        end
        rst_n = 1'b1; acc = 3'b111; ack = 1'b0;
        advance();
        @(negedge clk);
        checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL rst_first_grant got=%b exp=001", grant_o); end
        acc = '0;
        repeat (3) advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    if ($urandom_range(0, 7) == 0) acc[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    acc[k] = 1'b1;
                end
            end
            rst_n = ($urandom_range(0, 299) != 0);
            idle  = ((c % 300) > 200) ? 1'b0 : ($urandom_range(0, 3) != 0);
            ack   = 1'($urandom_range(0, 1));
            adr   = {$urandom(), $urandom(), $urandom()};
            dat   = 48'({$urandom(), $urandom()});
            sel   = 6'($urandom());
            we    = 3'($urandom());
            cdat  = 16'($urandom());
            @(negedge clk);
            checks++;
            if (dut_vec !== m_out()) begin
                errors++; $display("FAIL random cycle=%0d got=%h exp=%h", c, dut_vec, m_out());
            end
            advance();
        end
        rst_n = 1'b1; acc = '0; ack = 1'b0; idle = 1'b1;
        repeat (3) advance();
    endtask

    initial begin
        rst_n = 1'b0; acc = '0; adr = '0; dat = '0; sel = '0; we = '0;
        idle = 1'b0; ack = 1'b0; cdat = '0;
        m_phase = 0; m_owner = -1; m_beats = 0; m_last = N - 1;
        for (int k = 0; k < N; k++) m_wait[k] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_stray_ack();
        test_single_port();
        test_round_robin();
        test_starvation();
        test_drop_last_ack();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
